silife_gen_scheduler: RTL



---
 rtl/silife_gen_scheduler_pkg.sv | 18 +
 rtl/silife_sched_timer.sv | 27 ++
 rtl/silife_gen_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/silife_gen_scheduler_pkg.sv
// rtl/silife_gen_scheduler_pkg.sv - shared state encoding and default widths for the generation scheduler
package silife_sched_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ARM  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_WAIT = WAIT,
        ST_ARM  = ARM
    } sched_state_t;

    localparam int DEF_PERIOD_BITS = 24;
    localparam int DEF_COUNT_BITS  = 16;
    localparam int DEF_GEN_BITS    = 32;

endpackage

// File: rtl/silife_sched_timer.sv
// rtl/silife_sched_timer.sv - loadable down-counter with zero flag for the inter-generation wait
module silife_sched_timer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/silife_gen_scheduler.sv
// rtl/silife_gen_scheduler.sv - grid step sequencer; SILIFE_SCHED_FRAME_SYNC_EN adds i_frame_busy hold-off
module silife_gen_scheduler
    import silife_sched_pkg::*;
#(
    parameter int PERIOD_BITS = DEF_PERIOD_BITS,
    parameter int COUNT_BITS  = DEF_COUNT_BITS,
    parameter int GEN_BITS    = DEF_GEN_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_stop,
    input  logic [PERIOD_BITS-1:0] i_period,
    input  logic [COUNT_BITS-1:0]  i_limit,
    input  logic                   i_hold,
    input  logic                   i_sync_busy,
`ifdef SILIFE_SCHED_FRAME_SYNC_EN
    input  logic                   i_frame_busy,
`endif
    input  logic                   i_irq_clear,
    output logic                   o_grid_enable,
    output logic                   o_running,
    output logic [GEN_BITS-1:0]    o_gen_count,
    output logic [COUNT_BITS-1:0]  o_remaining,
    output logic                   o_done_irq
);

    sched_state_t state;
    logic         single;
    logic         limit_active;
    logic         fire_ok;
    logic         last_gen;
    logic         timer_load;
    logic         timer_zero;

`ifdef SILIFE_SCHED_FRAME_SYNC_EN
    assign fire_ok = !i_hold && !i_sync_busy && !i_frame_busy;
`else
    assign fire_ok = !i_hold && !i_sync_busy;
`endif

    assign last_gen = single || (limit_active && o_remaining == COUNT_BITS'(1));

    // Timer reloads on run start and on every fire that continues the run.
    assign timer_load = !i_stop &&
                        (((state == ST_IDLE) && i_run) ||
                         ((state == ST_ARM) && fire_ok && !last_gen));

    silife_sched_timer #(
        .WIDTH (PERIOD_BITS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .enable     (state == ST_WAIT),
        .load_value (i_period),
        .zero       (timer_zero)
    );

    assign o_running = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            single        <= 1'b0;
            limit_active  <= 1'b0;
            o_grid_enable <= 1'b0;
            o_gen_count   <= '0;
            o_remaining   <= '0;
            o_done_irq    <= 1'b0;
        end else begin
            o_grid_enable <= 1'b0;
            if (i_irq_clear) begin
                o_done_irq <= 1'b0;
            end
            if (i_stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_run) begin
                            state        <= ST_WAIT;
                            o_remaining  <= i_limit;
                            limit_active <= (i_limit != '0);
                            single       <= 1'b0;
                        end else if (i_step) begin
                            // A single step is not a limited run; leave o_remaining alone.
                            state        <= ST_ARM;
                            single       <= 1'b1;
                            limit_active <= 1'b0;
                        end
                    end
                    ST_WAIT: begin
                        if (timer_zero) begin
                            state <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (fire_ok) begin
                            o_grid_enable <= 1'b1;
                            o_gen_count   <= o_gen_count + GEN_BITS'(1);
                            if (limit_active) begin
                                o_remaining <= o_remaining - COUNT_BITS'(1);
                            end
                            if (last_gen) begin
                                state      <= ST_IDLE;
                                o_done_irq <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
